// File: rtl/link_master_burst.sv
// Burst master for the 4-phase req/ack link: buffers up to DEPTH words, then sends the first len of them in load order.
// Optional ack-wait timeout is compiled in with `define LINK_TIMEOUT_EN.
module link_master_burst #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = $clog2(DEPTH + 1),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              ack,
  output logic              req,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, FIN} state_t;

  // Link handshake: req rises with data already stable, stays up until ack is
  // sampled high, then the next req may only rise after ack is sampled low.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q, idx_q, len_q, sent_cnt_q, idx_nxt;
  logic [DATA_W-1:0] data_q;
  logic              req_q, busy_q, done_q, err_q;
  logic              wr_ok, accept, reject, ack_hi, next_word, fin_word, tmo, wait_hit;

  assign idx_nxt = idx_q + CNT_W'(1);
  assign wr_ok   = (state_q == IDLE) && wr_en && (wr_cnt_q < CNT_W'(DEPTH));

`ifdef LINK_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TW-1:0] wait_q;

  // Counts cycles spent in the current SEND/WAIT_LO visit; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (state_d != state_q) begin
      wait_q <= '0;
    end else if (state_q == SEND || state_q == WAIT_LO) begin
      wait_q <= wait_q + TW'(1);
    end
  end

  assign wait_hit = (wait_q == TW'(TIMEOUT_CYC - 1));
`else
  assign wait_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    ack_hi    = 1'b0;
    next_word = 1'b0;
    fin_word  = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        // Length is judged against the fill level before any same-cycle write.
        if (start) begin
          if (len == '0 || len > wr_cnt_q) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (ack) begin
          ack_hi  = 1'b1;
          state_d = WAIT_LO;
        end else if (wait_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        if (!ack) begin
          if (sent_cnt_q == len_q) begin
            fin_word = 1'b1;
            state_d  = FIN;
          end else begin
            next_word = 1'b1;
            state_d   = SEND;
          end
        end else if (wait_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[wr_cnt_q[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      sent_cnt_q <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_ok) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (reject) err_q <= 1'b1;
      if (accept) begin
        err_q      <= 1'b0;
        sent_cnt_q <= '0;
        idx_q      <= '0;
        len_q      <= len;
        data_q     <= buf_q[0];
        req_q      <= 1'b1;
        busy_q     <= 1'b1;
      end
      if (ack_hi) begin
        req_q      <= 1'b0;
        sent_cnt_q <= sent_cnt_q + CNT_W'(1);
      end
      if (next_word) begin
        idx_q  <= idx_nxt;
        data_q <= buf_q[idx_nxt[IDX_W-1:0]];
        req_q  <= 1'b1;
      end
      // done is registered on entry to FIN so it is high exactly while in FIN.
      if (fin_word) begin
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        wr_cnt_q <= '0;
      end
      if (tmo) begin
        req_q  <= 1'b0;
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign req      = req_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign sent_cnt = sent_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_link_master_burst.sv
// Self-checking bench for link_master_burst: randomized loads/bursts against a queue-based reference model.
module tb_link_master_burst;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 4;
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int TIMEOUT_CYC = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic              ack = 1'b0;
  logic              req, busy, done, err;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  sent_cnt, wr_cnt;

  int checks = 0;
  int failures = 0;

  // reference model: words the buffer should hold, words expected/observed on the link
  logic [DATA_W-1:0] mdl_buf[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int done_seen = 0;

  // slave behaviour knobs
  bit slave_on = 1'b1;
  int slave_delay = 0;
  int slave_hold = 0;
  int sl_cnt = 0;

  link_master_burst #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .len(len), .ack(ack), .req(req), .data(data), .busy(busy), .done(done),
    .err(err), .sent_cnt(sent_cnt), .wr_cnt(wr_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- link slave (changes ack on falling edges) ----------------
  always @(negedge clk) begin
    if (!slave_on || !rst_n) begin
      ack = 1'b0;
      sl_cnt = 0;
    end else if (!ack) begin
      if (req) begin
        if (sl_cnt >= slave_delay) begin ack = 1'b1; sl_cnt = 0; end
        else sl_cnt++;
      end else begin
        sl_cnt = 0;
      end
    end else if (!req) begin
      if (sl_cnt >= slave_hold) begin ack = 1'b0; sl_cnt = 0; end
      else sl_cnt++;
    end
  end

  // ---------------- link monitor ----------------
  logic              req_prev = 1'b0;
  logic              done_prev = 1'b0;
  logic [DATA_W-1:0] data_prev = '0;

  always @(posedge clk) begin
    #1;
    if (req && !req_prev) begin
      got_q.push_back(data);
      checks++;
      if (ack !== 1'b0) begin
        failures++;
        $display("FAIL req_rise_while_ack: ack=%0b required 0", ack);
      end
    end
    if (req && req_prev) begin
      checks++;
      if (data !== data_prev) begin
        failures++;
        $display("FAIL data_stable: data=%0h required %0h", data, data_prev);
      end
    end
    if (done) begin
      done_seen++;
      checks++;
      if (done_prev || busy) begin
        failures++;
        $display("FAIL done_pulse: done_prev=%0b busy=%0b required 0/0", done_prev, busy);
      end
    end
    req_prev  = req;
    done_prev = done;
    data_prev = data;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en = 1'b0;
    if (mdl_buf.size() < DEPTH) mdl_buf.push_back(w);
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) @(negedge clk);
    cyc(3);
  endtask

  // Starts a burst the model says is legal and checks the whole outcome.
  task automatic run_burst(input int l, input bit poke);
    got_q.delete();
    exp_q.delete();
    done_seen = 0;
    for (int i = 0; i < l; i++) exp_q.push_back(mdl_buf[i]);
    pulse_start(l);
    checks++;
    if (busy !== 1'b1 || req !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL burst_start: busy=%0b req=%0b err=%0b required 1/1/0", busy, req, err);
    end
    if (poke) begin
      cyc(3);
      wr_en = 1'b1; wr_data = DATA_W'($urandom); start = 1'b1; len = CNT_W'(1);
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      checks++;
      if (wr_cnt !== CNT_W'(mdl_buf.size()) || busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_ignores_inputs: wr_cnt=%0d busy=%0b required %0d/1", wr_cnt, busy, mdl_buf.size());
      end
    end
    wait_done(4000);
    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL done_count: saw %0d required 1", done_seen);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL word_count: sent %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL word_%0d: data=%0h required %0h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sent_cnt !== CNT_W'(l) || wr_cnt !== '0 || busy !== 1'b0 || req !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL burst_end: sent_cnt=%0d wr_cnt=%0d busy=%0b req=%0b err=%0b required %0d/0/0/0/0",
               sent_cnt, wr_cnt, busy, req, err, l);
    end
    mdl_buf.delete();
  endtask

  task automatic expect_reject(input int l, input string name);
    pulse_start(l);
    cyc(1);
    checks++;
    if (err !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || wr_cnt !== CNT_W'(mdl_buf.size())) begin
      failures++;
      $display("FAIL %s: err=%0b req=%0b busy=%0b wr_cnt=%0d required 1/0/0/%0d",
               name, err, req, busy, wr_cnt, mdl_buf.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        data !== '0 || sent_cnt !== '0 || wr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: req=%0b busy=%0b done=%0b err=%0b data=%0h sent=%0d wr=%0d required all 0",
               req, busy, done, err, data, sent_cnt, wr_cnt);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_full_burst();
    slave_delay = 0; slave_hold = 0;
    for (int i = 0; i < 4; i++) write_word(DATA_W'($urandom));
    run_burst(4, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) write_word(DATA_W'($urandom));
    checks++;
    if (wr_cnt !== CNT_W'(DEPTH)) begin
      failures++;
      $display("FAIL overflow_wr_cnt: wr_cnt=%0d required %0d", wr_cnt, DEPTH);
    end
    run_burst(2, 1'b0);
  endtask

  task automatic test_len_err();
    write_word(DATA_W'($urandom));
    write_word(DATA_W'($urandom));
    expect_reject(0, "len_zero");
    expect_reject(3, "len_over");
    run_burst(2, 1'b0);
  endtask

  task automatic test_slow_slave();
    slave_delay = 10; slave_hold = 5;
    for (int i = 0; i < 4; i++) write_word(DATA_W'($urandom));
    run_burst($urandom_range(1, 4), 1'b1);
    slave_delay = 0; slave_hold = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n, l;
      n = $urandom_range(0, 5);
      l = $urandom_range(0, DEPTH + 1);
      slave_delay = $urandom_range(0, 3);
      slave_hold = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) write_word(DATA_W'($urandom));
      checks++;
      if (wr_cnt !== CNT_W'(mdl_buf.size())) begin
        failures++;
        $display("FAIL rand_wr_cnt: wr_cnt=%0d required %0d", wr_cnt, mdl_buf.size());
      end
      if (l != 0 && l <= mdl_buf.size()) run_burst(l, 1'b0);
      else expect_reject(l, "rand_reject");
    end
    slave_delay = 0; slave_hold = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    slave_delay = 2; slave_hold = 0;
    for (int i = 0; i < 4; i++) write_word(DATA_W'($urandom));
    done_seen = 0;
    pulse_start(4);
    n = 0;
    while (!(sent_cnt == CNT_W'(1) && req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reach_word2: cycles=%0d required <200", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || data !== '0 || wr_cnt !== '0 ||
        sent_cnt !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: req=%0b busy=%0b err=%0b data=%0h wr=%0d sent=%0d done=%0b required all 0",
               req, busy, err, data, wr_cnt, sent_cnt, done);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_no_done: saw %0d required 0", done_seen);
    end
    mdl_buf.delete();
    slave_delay = 1;
    for (int i = 0; i < 3; i++) write_word(DATA_W'($urandom));
    run_burst(3, 1'b0);
    slave_delay = 0;
  endtask

`ifdef LINK_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    slave_on = 1'b0;
    for (int i = 0; i < 3; i++) write_word(DATA_W'($urandom));
    done_seen = 0;
    pulse_start(3);
    n = 0;
    while (req && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != TIMEOUT_CYC) begin
      failures++;
      $display("FAIL timeout_cycles: req high %0d cycles required %0d", n, TIMEOUT_CYC);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || wr_cnt !== CNT_W'(3) || sent_cnt !== '0 || done_seen != 0) begin
      failures++;
      $display("FAIL timeout_state: err=%0b busy=%0b wr=%0d sent=%0d done=%0d required 1/0/3/0/0",
               err, busy, wr_cnt, sent_cnt, done_seen);
    end
    slave_on = 1'b1;
    cyc(2);
    run_burst(3, 1'b0);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_burst();
    test_overflow();
    test_len_err();
    test_slow_slave();
    test_random();
    test_reset_mid();
`ifdef LINK_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
